// File: rtl/tx_word_packer.sv
// Packs a byte stream into 32-bit TX FIFO words, lane 0 first, one frame per start.
// Frame length is given in bits; a partial last word is zero-padded in its upper lanes.
//
// state | meaning
// IDLE  | waiting for start; rejects zero or non-byte-multiple sizes
// FILL  | accepting bytes into the word register, lane by lane
// PUSH  | presenting the word to the FIFO until it is not full
// DONE  | one-cycle frame completion pulse
module tx_word_packer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  W_CLK,
   input  logic                  W_rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_size,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   input  logic                  W_Full,
   output logic                  W_inc,
   output logic [DATA_WIDTH-1:0] W_Data,
   output logic                  busy,
   output logic                  done,
   output logic                  size_err,
   output logic [15:0]           word_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      PUSH = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   remaining_q, remaining_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic [1:0]              lane_q, lane_d;
   logic [15:0]             word_cnt_q, word_cnt_d;
   logic                    size_err_q, size_err_d;
   logic                    size_ok;

   assign size_ok = (data_size != '0) && (data_size[2:0] == 3'b000);

   always_ff @(posedge W_CLK or negedge W_rst_n) begin
      if (!W_rst_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         word_q      <= '0;
         lane_q      <= 2'd0;
         word_cnt_q  <= 16'd0;
         size_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         word_q      <= word_d;
         lane_q      <= lane_d;
         word_cnt_q  <= word_cnt_d;
         size_err_q  <= size_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      word_d      = word_q;
      lane_d      = lane_q;
      word_cnt_d  = word_cnt_q;
      size_err_d  = 1'b0;
      byte_ready  = 1'b0;
      W_inc       = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (size_ok) begin
                  remaining_d = data_size;
                  word_d      = '0;
                  lane_d      = 2'd0;
                  word_cnt_d  = 16'd0;
                  state_d     = FILL;
               end else begin
                  size_err_d = 1'b1;
               end
            end
         end
         FILL: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               word_d[{lane_q, 3'b000} +: 8] = byte_in;
               lane_d      = lane_q + 2'd1;
               remaining_d = remaining_q - DATA_WIDTH'(8);
               // remaining is always a byte multiple here, so hitting 8 means this byte ends the frame
               if ((lane_q == 2'd3) || (remaining_q == DATA_WIDTH'(8))) begin
                  state_d = PUSH;
               end
            end
         end
         PUSH: begin
            W_inc = !W_Full;
            if (!W_Full) begin
               word_cnt_d = word_cnt_q + 16'd1;
               word_d     = '0;
               lane_d     = 2'd0;
               state_d    = (remaining_q == '0) ? DONE : FILL;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign W_Data   = word_q;
   assign busy     = (state_q != IDLE);
   assign size_err = size_err_q;
   assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_tx_word_packer.sv
// Scoreboard bench for tx_word_packer: expected words are queued as each frame's bytes
// are chosen and popped whenever the packer strobes W_inc.
module tb_tx_word_packer;

   logic        W_CLK = 1'b0;
   logic        W_rst_n;
   logic        start;
   logic [31:0] data_size;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        W_Full;
   logic        W_inc;
   logic [31:0] W_Data;
   logic        busy;
   logic        done;
   logic        size_err;
   logic [15:0] word_cnt;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          done_cnt = 0;
   int          winc_cnt = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  bq[$];

   always #5 W_CLK = ~W_CLK;

   tx_word_packer #(.DATA_WIDTH(32)) dut (
      .W_CLK      (W_CLK),
      .W_rst_n    (W_rst_n),
      .start      (start),
      .data_size  (data_size),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .W_Full     (W_Full),
      .W_inc      (W_inc),
      .W_Data     (W_Data),
      .busy       (busy),
      .done       (done),
      .size_err   (size_err),
      .word_cnt   (word_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge W_CLK) begin
      if (W_rst_n) begin
         if (done) done_cnt++;
         if (W_inc) begin
            winc_cnt++;
            chk("inc_while_full", {31'd0, W_Full}, 32'd0);
            if (exp_q.size() == 0) chk("unexpected_word", 32'(exp_q.size()), 32'd1);
            else chk("word", W_Data, exp_q.pop_front());
         end
      end
   end

   // Model of the packing: lane k%4 of word k/4, unused upper lanes zero.
   task automatic queue_expected();
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < bq.size(); k++) begin
         w[8*(k%4) +: 8] = bq[k];
         if ((k % 4 == 3) || (k == bq.size() - 1)) begin
            exp_q.push_back(w);
            w = '0;
         end
      end
   endtask

   task automatic begin_frame(input logic [31:0] size);
      done_cnt = 0;
      @(negedge W_CLK);
      start     = 1'b1;
      data_size = size;
      @(negedge W_CLK);
      start = 1'b0;
   endtask

   task automatic feed(input bit rand_valid, input bit poke_start);
      int idx;
      int guard;
      idx   = 0;
      guard = 0;
      while (idx < bq.size() && guard < 2000) begin
         if (guard > 0) @(negedge W_CLK);
         guard++;
         byte_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
         byte_in    = bq[idx];
         if (poke_start) begin
            start     = ($urandom_range(0, 3) == 0);
            data_size = 32'd32;
         end
         if (byte_ready && byte_valid) idx++;
      end
      @(negedge W_CLK);
      byte_valid = 1'b0;
      start      = 1'b0;
      if (idx < bq.size()) chk("feed_timeout", 32'(idx), 32'(bq.size()));
   endtask

   task automatic finish_frame(input logic [15:0] exp_words);
      int g;
      g = 0;
      while (done_cnt == 0 && g < 200) begin
         @(posedge W_CLK);
         #2;
         g++;
      end
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge W_CLK);
      #2;
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("word_cnt", {16'd0, word_cnt}, {16'd0, exp_words});
      chk("words_left", 32'(exp_q.size()), 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int w0;
      W_rst_n    = 1'b0;
      start      = 1'b0;
      data_size  = '0;
      byte_in    = '0;
      byte_valid = 1'b0;
      W_Full     = 1'b0;
      #1;
      chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_W_inc", {31'd0, W_inc}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_size_err", {31'd0, size_err}, 32'd0);
      chk("rst_W_Data", W_Data, 32'd0);
      chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
      #21;
      @(negedge W_CLK);
      W_rst_n = 1'b1;

      // 64-bit frame, no stalls
      bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      queue_expected();
      begin_frame(32'd64);
      feed(1'b0, 1'b0);
      finish_frame(16'd2);

      // 40-bit frame: partial second word
      bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      queue_expected();
      begin_frame(32'd40);
      feed(1'b0, 1'b0);
      finish_frame(16'd2);

      // rejected sizes
      w0 = winc_cnt;
      foreach (bq[i]) bq[i] = 8'h00;
      for (int t = 0; t < 2; t++) begin
         @(negedge W_CLK);
         start     = 1'b1;
         data_size = (t == 0) ? 32'd0 : 32'd12;
         @(posedge W_CLK);
         #2;
         chk("size_err_pulse", {31'd0, size_err}, 32'd1);
         chk("size_err_busy", {31'd0, busy}, 32'd0);
         @(negedge W_CLK);
         start = 1'b0;
         @(posedge W_CLK);
         #2;
         chk("size_err_clear", {31'd0, size_err}, 32'd0);
      end
      chk("size_err_no_winc", 32'(winc_cnt - w0), 32'd0);
      chk("size_err_word_cnt", {16'd0, word_cnt}, 32'd2);

      // FIFO full held for 10 cycles in PUSH
      W_Full = 1'b1;
      bq = {8'h11, 8'h22, 8'h33, 8'h44};
      queue_expected();
      w0 = winc_cnt;
      begin_frame(32'd32);
      feed(1'b0, 1'b0);
      for (int g = 0; g < 20 && !(busy && !byte_ready); g++) begin
         @(posedge W_CLK);
         #2;
      end
      for (int i = 0; i < 10; i++) begin
         chk("full_no_winc", {31'd0, W_inc}, 32'd0);
         chk("full_data_hold", W_Data, 32'h44332211);
         @(posedge W_CLK);
         #2;
      end
      W_Full = 1'b0;
      finish_frame(16'd1);
      chk("full_single_winc", 32'(winc_cnt - w0), 32'd1);

      // reset mid-frame after the third byte
      bq = {8'h51, 8'h52, 8'h53};
      begin_frame(32'd64);
      feed(1'b0, 1'b0);
      #1;
      W_rst_n = 1'b0;
      #1;
      chk("mid_rst_W_Data", W_Data, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("mid_rst_W_inc", {31'd0, W_inc}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_word_cnt", {16'd0, word_cnt}, 32'd0);
      @(negedge W_CLK);
      W_rst_n = 1'b1;
      w0 = winc_cnt;
      repeat (5) @(posedge W_CLK);
      #2;
      chk("post_rst_idle", {31'd0, busy}, 32'd0);
      chk("post_rst_no_winc", 32'(winc_cnt - w0), 32'd0);
      bq = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
      queue_expected();
      begin_frame(32'd32);
      feed(1'b0, 1'b0);
      finish_frame(16'd1);

      // 256-bit frame, random byte_valid, stray starts while busy
      bq.delete();
      for (int i = 0; i < 32; i++) bq.push_back(8'($urandom_range(0, 255)));
      queue_expected();
      begin_frame(32'd256);
      feed(1'b1, 1'b1);
      finish_frame(16'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
